// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants for the iterative integer divider
//
// Purpose: FSM state encodings, the 32-bit word width and the quotient
// value returned for a zero divisor, shared by every file of div_unit.
// Ports: none (package).
package div_unit_pkg;

  // FSM state encodings (2 bits)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the W (32-bit) instruction variants
  localparam int WORD_W = 32;

  // Divide-by-zero quotient is every bit set; replicated to XLEN at use
  localparam logic DIV0_QUO_BIT = 1'b1;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider (div/divu/rem/remu + W forms)
//
// Purpose: one quotient bit per cycle; zero-divisor and signed-overflow
// requests are answered without iterating.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake
//   dividend, divisor    XLEN-bit operands
//   is_signed            signed op (div/rem) vs unsigned (divu/remu)
//   is_word              32-bit W variant, result sign-extended from bit 31
//   is_rem               return remainder instead of quotient
//   kill                 flush: drop any in-flight work, return to idle
//   out_valid/out_ready  result handshake
//   result               quotient or remainder
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic            is_rem,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] remReg;
  logic [XLEN-1:0] quoReg;
  logic [XLEN-1:0] dvsReg;
  logic            negQ;
  logic            negR;
  logic            wordOp;
  logic            remOp;

  // Narrow W results are always sign-extended from bit 31
  function automatic logic [XLEN-1:0] fmtWord(input logic [XLEN-1:0] x, input logic w);
    fmtWord = w ? {{(XLEN-WORD_W){x[WORD_W-1]}}, x[WORD_W-1:0]} : x;
  endfunction

  // ---------------- request decode ----------------
  logic [XLEN-1:0] effDvd;
  logic [XLEN-1:0] effDvs;
  logic [XLEN-1:0] magDvd;
  logic [XLEN-1:0] magDvs;
  logic [XLEN-1:0] minNeg;
  logic            dvdNeg;
  logic            dvsNeg;
  logic            isDivZero;
  logic            isOverflow;

  always_comb begin
    effDvd = dividend;
    effDvs = divisor;
    if (is_word) begin
      effDvd = {{(XLEN-WORD_W){is_signed & dividend[WORD_W-1]}}, dividend[WORD_W-1:0]};
      effDvs = {{(XLEN-WORD_W){is_signed & divisor[WORD_W-1]}}, divisor[WORD_W-1:0]};
    end
    dvdNeg = is_signed & effDvd[XLEN-1];
    dvsNeg = is_signed & effDvs[XLEN-1];
    magDvd = dvdNeg ? -effDvd : effDvd;
    magDvs = dvsNeg ? -effDvs : effDvs;
    // Most-negative value of the effective width, already sign-extended
    minNeg = is_word ? {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}}
                     : {1'b1, {(XLEN-1){1'b0}}};
    isDivZero  = (effDvs == '0);
    isOverflow = is_signed && (effDvd == minNeg) && (effDvs == '1);
  end

  // ---------------- one restoring step ----------------
  // The dividend magnitude sits left-aligned in quoReg and is shifted out
  // MSB-first into the partial remainder while quotient bits shift in at
  // the bottom, so for W ops the quotient ends up in the low 32 bits.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] remNext;
  logic [XLEN-1:0] quoNext;
  logic [XLEN-1:0] qSigned;
  logic [XLEN-1:0] rSigned;
  logic [XLEN-1:0] finalRes;

  always_comb begin
    shifted  = {remReg, quoReg[XLEN-1]};
    diff     = shifted - {1'b0, dvsReg};
    fits     = ~diff[XLEN];
    remNext  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quoNext  = {quoReg[XLEN-2:0], fits};
    qSigned  = negQ ? -quoNext : quoNext;
    rSigned  = negR ? -remNext : remNext;
    finalRes = fmtWord(remOp ? rSigned : qSigned, wordOp);
  end

  assign in_ready  = (state == ST_IDLE) && !kill;
  assign out_valid = (state == ST_DONE);

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      remReg <= '0;
      quoReg <= '0;
      dvsReg <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      wordOp <= 1'b0;
      remOp  <= 1'b0;
      result <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            negQ   <= dvdNeg ^ dvsNeg;
            negR   <= dvdNeg;
            wordOp <= is_word;
            remOp  <= is_rem;
            dvsReg <= magDvs;
            if (isDivZero) begin
              result <= fmtWord(is_rem ? effDvd : {XLEN{DIV0_QUO_BIT}}, is_word);
              state  <= ST_DONE;
            end else if (isOverflow) begin
              result <= fmtWord(is_rem ? '0 : effDvd, is_word);
              state  <= ST_DONE;
            end else begin
              remReg <= '0;
              quoReg <= is_word ? (magDvd << (XLEN - WORD_W)) : magDvd;
              cnt    <= is_word ? CNT_W'(WORD_W) : CNT_W'(XLEN);
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          remReg <= remNext;
          quoReg <= quoNext;
          cnt    <= cnt - 1'b1;
          // Last step also applies the signs, so DONE carries the final value
          if (cnt == CNT_W'(1)) begin
            result <= finalRes;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        is_word = 1'b0;
  logic        is_rem = 1'b0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .is_word(is_word), .is_rem(is_rem), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   applied = 0;
  int   miscompares = 0;
  bit   prevValid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Monitor: latency on the first cycle of out_valid, value on handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got result 0x%016h with nothing outstanding", result);
      end else begin
        if (!prevValid) begin
          applied++;
          if (cycle - sbq[0].acc != sbq[0].lat) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", sbq[0].name, cycle - sbq[0].acc, sbq[0].lat);
          end
        end
        if (out_ready) begin
          exp_t e;
          e = sbq.pop_front();
          applied++;
          if (result !== e.res) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, result, e.res);
          end
        end
      end
    end
    prevValid = rst_n && out_valid && !out_ready;
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic w, input logic r, input logic [63:0] exp,
                       input int lat, input string nm, input bit track);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      applied++;
      miscompares++;
      $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, expected 1", nm, t);
      return;
    end
    dividend = a; divisor = b; is_signed = s; is_word = w; is_rem = r;
    in_valid = 1'b1;
    if (track) sbq.push_back('{res: exp, acc: cycle, lat: lat, name: nm});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    //    dividend                divisor                 s  w  r  expected                lat
    issue(64'd100,                64'd7,                  0, 0, 0, 64'd14,                 65, "divu_100_7",   1);
    issue(64'd100,                64'd7,                  0, 0, 1, 64'd2,                  65, "remu_100_7",   1);
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2",     1);
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2",     1);
    issue(64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7_m2",     1);
    issue(64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 64'd1,                  65, "rem_7_m2",     1);
    issue(64'd5,                  64'd0,                  0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1,  "divu_5_0",     1);
    issue(64'd5,                  64'd0,                  0, 0, 1, 64'd5,                  1,  "remu_5_0",     1);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf",   1);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1, 64'd0,                1,  "remw_ovf",     1);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 1, "div_ovf",    1);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 64'd0,                1,  "rem_ovf",      1);
    issue(64'hAAAA_AAAA_FFFF_FFF0, 64'h5555_5555_0000_0003, 0, 1, 0, 64'h0000_0000_5555_5550, 33, "divuw_trunc", 1);
    issue(64'h1234_5678_FFFF_FFFF, 64'd1,                 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw_sext",   1);
    issue(64'h0000_0000_FFFF_FF9C, 64'd7,                 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF2, 33, "divw_m100_7",  1);
    issue(64'h0000_0000_FFFF_FF9C, 64'd7,                 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "remw_m100_7",  1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                0, 0, 0, 64'h0FFF_FFFF_FFFF_FFFF, 65, "divu_max_16",  1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                0, 0, 1, 64'hF,                  65, "remu_max_16",  1);
    issue(64'd5,                  64'hFFFF_FFFF_0000_0000, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1,  "divuw_5_0",    1);

    // Back-pressure: result held while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    issue(64'd100, 64'd7, 0, 0, 0, 64'd14, 65, "divu_stall", 1);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stall_result_%0d", i), result, 64'd14);
      chk($sformatf("stall_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_consume", {63'd0, in_ready}, 64'd1);

    // Kill in the middle of an iteration; nothing may come out
    issue(64'd100, 64'd7, 0, 0, 0, 64'd0, 0, "divu_killed", 0);
    repeat (19) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill_in_ready", {63'd0, in_ready}, 64'd1);
    chk("kill_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(negedge clk);
    issue(64'd9, 64'd3, 0, 0, 0, 64'd3, 65, "divu_9_3", 1);

    // Kill together with in_valid: the request is dropped
    repeat (70) @(negedge clk);
    dividend = 64'd50; divisor = 64'd5; is_signed = 1'b0; is_word = 1'b0; is_rem = 1'b0;
    kill = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("kill_valid_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    kill = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("kill_valid_idle", {63'd0, in_ready}, 64'd1);
    repeat (80) @(negedge clk);

    // Reset mid-iteration clears everything and emits nothing
    issue(64'd100, 64'd7, 0, 0, 0, 64'd0, 0, "divu_reset", 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (80) @(negedge clk);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Hard stop if something wedges the stimulus
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares + 1);
    $fatal(1);
  end

endmodule
